// File: rtl/cnn1d_pkg.sv
// Shared constants and helpers for the 1D CNN datapath.
package cnn1d_pkg;

    localparam int MULT_PIPE_DEFAULT = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adder_tree.sv
// Registered binary adder tree: N_IN (power of two, >= 2) inputs, clog2(N_IN) register levels.
module adder_tree #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 27
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [N_IN*WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]        sum_out
);

    // Heap-ordered nodes: node k sums children 2k and 2k+1; leaves are the inputs.
    logic [WIDTH-1:0] node_d [1:N_IN-1];
    logic [WIDTH-1:0] node_q [1:N_IN-1];

    always_comb begin
        for (int k = 1; k < N_IN; k++) begin
            node_d[k] = '0;
        end
        for (int k = N_IN / 2; k < N_IN; k++) begin
            node_d[k] = data_in[(2*k-N_IN)*WIDTH +: WIDTH]
                      + data_in[(2*k-N_IN+1)*WIDTH +: WIDTH];
        end
        for (int k = 1; k < N_IN / 2; k++) begin
            node_d[k] = node_q[2*k] + node_q[2*k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (en) node_q <= node_d;
    end

    assign sum_out = node_q[1];

endmodule

// File: rtl/mult.sv
// Pipelined multiplier wrapper with clock enable; SIGNED selects two's-complement operands.
module mult #(
    parameter int DATA_WIDTH = 12,
    parameter int PIPE_WIDTH = 2,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                      clk,
    input  logic                      clken,
    input  logic [DATA_WIDTH-1:0]     dataa,
    input  logic [DATA_WIDTH-1:0]     datab,
    output logic [2*DATA_WIDTH-1:0]   result
);

    logic [2*DATA_WIDTH-1:0] a_ext;
    logic [2*DATA_WIDTH-1:0] b_ext;
    logic [2*DATA_WIDTH-1:0] product;
    logic [2*DATA_WIDTH-1:0] pipe_d [PIPE_WIDTH];
    logic [2*DATA_WIDTH-1:0] pipe_q [PIPE_WIDTH];

    // Low 2*DATA_WIDTH bits of the widened product are exact for both modes.
    assign a_ext   = {{DATA_WIDTH{SIGNED & dataa[DATA_WIDTH-1]}}, dataa};
    assign b_ext   = {{DATA_WIDTH{SIGNED & datab[DATA_WIDTH-1]}}, datab};
    assign product = a_ext * b_ext;

    always_comb begin
        pipe_d[0] = product;
        for (int i = 1; i < PIPE_WIDTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clken) pipe_q <= pipe_d;
    end

    assign result = pipe_q[PIPE_WIDTH-1];

endmodule

// File: rtl/mult_reduce_par.sv
// Multiply-reduce engine: LANES products per beat, adder tree, window accumulator.
module mult_reduce_par
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int NUM_ELEMENTS   = 5,
    parameter int LANES          = 1,
    parameter int PIPE_WIDTH     = MULT_PIPE_DEFAULT,
    parameter bit SIGNED         = 1'b1,
    localparam int RESULT_WIDTH  = 2*DATA_WIDTH + clog2(NUM_ELEMENTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          mult_reduce_ready_in,
    input  logic                          mult_reduce_valid_in,
    input  logic [LANES*DATA_WIDTH-1:0]   mult_reduce_dataa_in,
    input  logic [LANES*DATA_WIDTH-1:0]   mult_reduce_datab_in,
    input  logic                          mult_reduce_ready_out,
    output logic                          mult_reduce_valid_out,
    output logic [RESULT_WIDTH-1:0]       mult_reduce_result_out
);

    localparam int BEATS       = NUM_ELEMENTS / LANES;
    localparam int TREE_STAGES = clog2(LANES);
    localparam int VLD_DEPTH   = PIPE_WIDTH + TREE_STAGES;
    localparam int CNT_W       = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
    localparam int PROD_W      = 2*DATA_WIDTH;

    logic                         en;
    logic [VLD_DEPTH-1:0]         vld_d, vld_q;
    logic [LANES*RESULT_WIDTH-1:0] prod_ext;
    logic [RESULT_WIDTH-1:0]      tree_sum;
    logic [RESULT_WIDTH-1:0]      acc_d, acc_q;
    logic [RESULT_WIDTH-1:0]      result_d, result_q;
    logic [CNT_W-1:0]             cnt_d, cnt_q;
    logic                         valid_out_d, valid_out_q;

    // Whole datapath freezes only while a finished result waits on downstream.
    assign en                   = !(valid_out_q && !mult_reduce_ready_out);
    assign mult_reduce_ready_in = en;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PROD_W-1:0] prod;

        mult #(
            .DATA_WIDTH (DATA_WIDTH),
            .PIPE_WIDTH (PIPE_WIDTH),
            .SIGNED     (SIGNED)
        ) u_mult (
            .clk    (clk),
            .clken  (en),
            .dataa  (mult_reduce_dataa_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .datab  (mult_reduce_datab_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .result (prod)
        );

        if (SIGNED) begin : g_sext
            assign prod_ext[i*RESULT_WIDTH +: RESULT_WIDTH] = RESULT_WIDTH'($signed(prod));
        end else begin : g_zext
            assign prod_ext[i*RESULT_WIDTH +: RESULT_WIDTH] = RESULT_WIDTH'(prod);
        end
    end

    if (LANES > 1) begin : g_tree
        adder_tree #(
            .N_IN  (LANES),
            .WIDTH (RESULT_WIDTH)
        ) u_adder_tree (
            .clk     (clk),
            .en      (en),
            .data_in (prod_ext),
            .sum_out (tree_sum)
        );
    end else begin : g_no_tree
        assign tree_sum = prod_ext;
    end

    always_comb begin
        vld_d       = vld_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        valid_out_d = valid_out_q;

        if (en) vld_d = VLD_DEPTH'({vld_q, mult_reduce_valid_in});

        if (valid_out_q && mult_reduce_ready_out) valid_out_d = 1'b0;

        // A completing window in the handshake cycle keeps valid_out high with new data.
        if (en && vld_q[VLD_DEPTH-1]) begin
            if (cnt_q < CNT_W'(BEATS - 1)) begin
                acc_d = acc_q + tree_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                result_d    = acc_q + tree_sum;
                valid_out_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            valid_out_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign mult_reduce_valid_out  = valid_out_q;
    assign mult_reduce_result_out = result_q;

endmodule

// File: tb/tb_mult_reduce_par.sv
// Bench for mult_reduce_par: unsigned and signed single-lane instances share stimulus, plus a 4-lane instance.
module tb_mult_reduce_par;

    localparam int DW = 12;
    localparam int RW = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            rdy_out, vin;
    logic [DW-1:0]   da, db;
    logic            rdy_in_a, vout_a, rdy_in_s, vout_s;
    logic [RW-1:0]   res_a, res_s;
    logic            rdy_out4, vin4;
    logic [4*DW-1:0] da4, db4;
    logic            rdy_in4, vout4;
    logic [RW-1:0]   res4;

    mult_reduce_par #(.DATA_WIDTH(DW), .NUM_ELEMENTS(5), .LANES(1), .PIPE_WIDTH(2), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .mult_reduce_ready_in(rdy_in_a), .mult_reduce_valid_in(vin),
        .mult_reduce_dataa_in(da), .mult_reduce_datab_in(db), .mult_reduce_ready_out(rdy_out),
        .mult_reduce_valid_out(vout_a), .mult_reduce_result_out(res_a));

    mult_reduce_par #(.DATA_WIDTH(DW), .NUM_ELEMENTS(5), .LANES(1), .PIPE_WIDTH(2), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .mult_reduce_ready_in(rdy_in_s), .mult_reduce_valid_in(vin),
        .mult_reduce_dataa_in(da), .mult_reduce_datab_in(db), .mult_reduce_ready_out(rdy_out),
        .mult_reduce_valid_out(vout_s), .mult_reduce_result_out(res_s));

    mult_reduce_par #(.DATA_WIDTH(DW), .NUM_ELEMENTS(8), .LANES(4), .PIPE_WIDTH(2), .SIGNED(1'b0)) u_dut_l4 (
        .clk(clk), .rst(rst), .mult_reduce_ready_in(rdy_in4), .mult_reduce_valid_in(vin4),
        .mult_reduce_dataa_in(da4), .mult_reduce_datab_in(db4), .mult_reduce_ready_out(rdy_out4),
        .mult_reduce_valid_out(vout4), .mult_reduce_result_out(res4));

    typedef struct {
        logic [4:0][DW-1:0] a;
        logic [4:0][DW-1:0] b;
        logic [RW-1:0]      exp_u;
        logic [RW-1:0]      exp_s;
    } win_t;

    win_t          tbl [5];
    logic [RW-1:0] q_u [$];
    logic [RW-1:0] q_s [$];
    logic [RW-1:0] q_l [$];
    int            res_cyc [$];

    int checks = 0, failures = 0, cyc = 0, drops = 0;
    int last_acc = 0, last_acc4 = 0, lat_a = -1, lat4 = -1;
    int stall_n, stall_bad;
    logic [RW-1:0] held;
    logic vout_a_prev = 1'b0, vout4_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_extra(input string name);
        checks++;
        failures++;
        $display("FAIL %s: result produced with empty scoreboard", name);
    endtask

    // Scoreboard compare on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rdy_out && !rdy_in_a) drops++;
            if (vout_a && !vout_a_prev) lat_a = cyc - last_acc;
            if (vout4 && !vout4_prev) lat4 = cyc - last_acc4;
            if (vout_a && rdy_out) begin
                if (q_u.size() == 0) sb_extra("sb_unsigned");
                else check("sb_unsigned", res_a, q_u.pop_front());
                res_cyc.push_back(cyc);
            end
            if (vout_s && rdy_out) begin
                if (q_s.size() == 0) sb_extra("sb_signed");
                else check("sb_signed", res_s, q_s.pop_front());
            end
            if (vout4 && rdy_out4) begin
                if (q_l.size() == 0) sb_extra("sb_lanes4");
                else check("sb_lanes4", res4, q_l.pop_front());
            end
        end
        vout_a_prev = vout_a;
        vout4_prev  = vout4;
    end

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_in_a && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: ready_in low for %0d cycles, required high", n);
        end
        last_acc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept4();
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_in4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL accept4_timeout: ready_in low for %0d cycles, required high", n);
        end
        last_acc4 = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_win(input int w);
        for (int i = 0; i < 5; i++) begin
            vin = 1'b1;
            da  = tbl[w].a[i];
            db  = tbl[w].b[i];
            wait_accept();
        end
        vin = 1'b0;
        q_u.push_back(tbl[w].exp_u);
        q_s.push_back(tbl[w].exp_s);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_u.size() != 0 || q_s.size() != 0 || q_l.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain", q_u.size() + q_s.size() + q_l.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            tbl[0].a[i] = 12'(i + 1); tbl[0].b[i] = 12'd2;
            tbl[1].a[i] = 12'd1;      tbl[1].b[i] = 12'd1;
            tbl[2].a[i] = 12'd2;      tbl[2].b[i] = 12'd3;
            tbl[3].a[i] = 12'hFFD;    tbl[3].b[i] = 12'd4;
            tbl[4].a[i] = 12'h800;    tbl[4].b[i] = 12'h800;
        end
        tbl[0].exp_u = 27'd30;       tbl[0].exp_s = 27'd30;
        tbl[1].exp_u = 27'd5;        tbl[1].exp_s = 27'd5;
        tbl[2].exp_u = 27'd30;       tbl[2].exp_s = 27'd30;
        tbl[3].exp_u = 27'd81860;    tbl[3].exp_s = 27'h7FFFFC4;
        tbl[4].exp_u = 27'd20971520; tbl[4].exp_s = 27'd20971520;

        rst = 1'b1; vin = 1'b0; da = '0; db = '0; rdy_out = 1'b1;
        vin4 = 1'b0; da4 = '0; db4 = '0; rdy_out4 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_u", vout_a, 0);
        check("rst_result_u", res_a, 0);
        check("rst_ready_u", rdy_in_a, 1);
        check("rst_valid_s", vout_s, 0);
        check("rst_result_s", res_s, 0);
        check("rst_ready_l4", rdy_in4, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic window and its latency.
        send_win(0);
        wait_idle();
        check("lat_basic", lat_a, 3);

        // Back-to-back windows, no gap.
        res_cyc.delete();
        send_win(1);
        send_win(2);
        wait_idle();
        check("b2b_count", res_cyc.size(), 2);
        if (res_cyc.size() == 2) check("b2b_spacing", res_cyc[1] - res_cyc[0], 5);

        // Signed-mode windows.
        send_win(3);
        send_win(4);
        wait_idle();

        // Backpressure: hold ready_out low across the first result.
        rdy_out = 1'b0;
        fork
            begin
                send_win(1);
                send_win(2);
            end
            begin
                stall_n = 0;
                @(negedge clk);
                while (!vout_a && stall_n < 100) begin
                    @(negedge clk);
                    stall_n++;
                end
                held      = res_a;
                stall_bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (rdy_in_a !== 1'b0 || vout_a !== 1'b1 || res_a !== held) stall_bad++;
                end
                check("stall_hold", stall_bad, 0);
                check("stall_value", held, 5);
                @(posedge clk);
                #1 rdy_out = 1'b1;
            end
        join
        wait_idle();

        // Four lanes with bubbles between the two beats.
        vin4 = 1'b1; da4 = {4{12'hFFF}}; db4 = {4{12'hFFF}};
        wait_accept4();
        vin4 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vin4 = 1'b1;
        wait_accept4();
        vin4 = 1'b0;
        q_l.push_back(27'd134152200);
        wait_idle();
        check("lat_l4", lat4, 5);

        // Reset after three beats of a window.
        for (int i = 0; i < 3; i++) begin
            vin = 1'b1; da = 12'd1; db = 12'd1;
            wait_accept();
        end
        vin = 1'b0;
        rst = 1'b1;
        q_u.delete(); q_s.delete(); q_l.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", vout_a, 0);
        check("midrst_result", res_a, 0);
        check("midrst_ready", rdy_in_a, 1);
        check("midrst_result_s", res_s, 0);
        @(posedge clk);
        #1;
        send_win(1);
        wait_idle();

        check("ready_drops", drops, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_reduce_par.md
# mult_reduce_par

Parametrised multiply-reduce engine for the 1D CNN datapath. Each accepted beat carries LANES operand pairs, which are multiplied in parallel, summed by a registered adder tree and accumulated over NUM_ELEMENTS pairs. It emits one dot-product result per window, with no dead cycle between windows and full AXI-style backpressure. It sits between the convolution window buffer and the activation stage.

## Interface
- DATA_WIDTH, 12, operand width per lane
- NUM_ELEMENTS, 5, pairs per window; must be a multiple of LANES
- LANES, 1, parallel multipliers per beat (power of two, ≥1)
- PIPE_WIDTH, 2, multiplier pipeline depth (≥1)
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
- RESULT_WIDTH (local), 2*DATA_WIDTH + clog2(NUM_ELEMENTS); holds the worst-case sum exactly
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- mult_reduce_ready_in  out  1  input beat accepted when high with valid_in
- mult_reduce_valid_in  in  1  input beat valid
- mult_reduce_dataa_in  in  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- mult_reduce_datab_in  in  LANES*DATA_WIDTH  same packing
- mult_reduce_ready_out  in  1  downstream ready
- mult_reduce_valid_out  out  1  result valid
- mult_reduce_result_out  out  RESULT_WIDTH  window sum

## Operation
- BEATS = NUM_ELEMENTS/LANES beats per window. TREE_STAGES = clog2(LANES).
- Global advance enable: en = !(valid_out && !ready_out). ready_in = en, driven combinationally.
- While en is high, the multiplier clken, valid shift pipe and tree registers all advance. While en is low, all of them hold.
- Each accepted beat enters a valid pipe of depth PIPE_WIDTH+TREE_STAGES. Bubbles (valid_in low) propagate as invalid slots and are not counted.
- Products are sign-extended when SIGNED=1 and zero-extended otherwise to RESULT_WIDTH before the tree.
- Accumulator stage, on a valid slot with en high:
  - If beat_count < BEATS-1: acc <= acc + tree_sum, beat_count++.
  - Otherwise: result_out <= acc + tree_sum, valid_out <= 1, acc <= 0, beat_count <= 0.
- The next window's first beat may follow in the very next cycle.
- valid_out clears when a handshake occurs and no new result completes in the same cycle. If a new result completes in that cycle, valid_out stays high and result_out updates.
- Reset values: ready_in = 1 (follows en), valid_out = 0, result_out = 0, acc = 0, beat_count = 0, valid pipe = all 0.
- Reset mid-window discards the partial sum and all in-flight beats. The first beat after reset starts a new window.
- No overflow is possible with the RESULT_WIDTH above; no saturation logic.

## Timing
- Latency: the final beat of a window accepted at cycle t gives valid_out high at t+PIPE_WIDTH+TREE_STAGES+1, assuming no stall.
- Throughput: one beat per cycle sustained. For LANES=1, NUM_ELEMENTS=5 this is one result every 5 cycles, with ready_in never dropping while ready_out is high.
- Stall: while valid_out is high and ready_out is low, ready_in is low and result_out is stable. Nothing in flight is lost or duplicated.
- ready_out high with valid_out low has no effect.

## Structure
- The shared package cnn1d_pkg holds clog2 and the default multiplier pipeline-depth constant; no new typedefs are needed.
- LANES instances of the existing mult wrapper. Each instance is clocked with clken = en and has a signed/unsigned mode set from SIGNED.
- New sub-module adder_tree (LANES inputs, TREE_STAGES register levels, with its own enable). Adder stage s is RESULT_WIDTH wide.

## Test plan
- Basic window, LANES=1, NUM_ELEMENTS=5, SIGNED=0:
  - Stimulus: a=1..5, b=2 on consecutive cycles.
  - Required: result 30; valid_out 3 cycles after the last beat; ready_in stays 1.
- Back-to-back windows:
  - Stimulus: two windows streamed with no gap (a=1, b=1 ×5, then a=2, b=3 ×5).
  - Required: results 5 then 30, five cycles apart; no ready_in deassertion.
- Backpressure:
  - Stimulus: hold ready_out=0 for 10 cycles after the first result while valid_in stays high.
  - Required: ready_in=0 and result_out stable throughout; after release the second window completes correctly with no lost or duplicated beat.
- Signed mode, SIGNED=1:
  - Stimulus: a=-3, b=4 ×5.
  - Required: result -60 (sign-extended, 0x...FC4).
  - Stimulus: a=-2048, b=-2048 ×5.
  - Required: 20971520 with no overflow.
- Parallel lanes, LANES=4, NUM_ELEMENTS=8, SIGNED=0:
  - Stimulus: all operands 4095, plus bubbles inserted between the 2 beats.
  - Required: result 8·4095² = 134152200; latency 2+2+1 cycles after the last beat.
- Mid-window reset:
  - Stimulus: assert rst for 1 cycle after 3 of 5 beats, then send a=1, b=1 ×5.
  - Required: all outputs at reset values during rst; the next result is 5, not 8.
